// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator CPU
// Optional memory handshake (mem_ready wait states) enabled by defining CU_MEM_HANDSHAKE_EN.
module control_unit #(
  parameter int DATA_W   = 16,
  parameter int OPCODE_W = 4,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ir_out,
  input  logic              acc_zero,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              mar_write,
  output logic              mbr_write,
  output logic              ir_write,
  output logic              acc_write,
  output logic              pc_sel,
  output logic              mar_sel,
  output logic [1:0]        alu_op,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              halted,
  output logic              illegal_op,
  output logic              instr_done
);

  typedef enum logic [2:0] {
    S_F_ADDR = 3'd0,
    S_F_MEM  = 3'd1,
    S_F_IR   = 3'd2,
    S_DECODE = 3'd3,
    S_E_MEM  = 3'd4,
    S_E_WB   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_JZ    = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(7);

  state_t              r_state;
  state_t              w_next;
  logic [OPCODE_W-1:0] w_opcode;
  logic                w_mem_ready;
  logic                w_unused;

  // IR only loads in F_IR, so ir_out is stable through DECODE/E_MEM/E_WB.
  assign w_opcode = ir_out[DATA_W-1 -: OPCODE_W];
  assign w_unused = ^{ir_out[ADDR_W-1:0], mem_ready};

`ifdef CU_MEM_HANDSHAKE_EN
  assign w_mem_ready = mem_ready;
`else
  assign w_mem_ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_F_ADDR;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    pc_write   = 1'b0;
    mar_write  = 1'b0;
    mbr_write  = 1'b0;
    ir_write   = 1'b0;
    acc_write  = 1'b0;
    pc_sel     = 1'b0;
    mar_sel    = 1'b0;
    alu_op     = 2'b00;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    instr_done = 1'b0;

    case (r_state)
      S_F_ADDR: begin
        mar_write = 1'b1;
        w_next    = S_F_MEM;
      end
      S_F_MEM: begin
        mem_rd = 1'b1;
        if (w_mem_ready) begin
          mbr_write = 1'b1;
          pc_write  = 1'b1;
          w_next    = S_F_IR;
        end
      end
      S_F_IR: begin
        ir_write = 1'b1;
        w_next   = S_DECODE;
      end
      S_DECODE: begin
        instr_done = 1'b1;
        w_next     = S_F_ADDR;
        case (w_opcode)
          OP_NOP: ;
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB: begin
            instr_done = 1'b0;
            mar_write  = 1'b1;
            mar_sel    = 1'b1;
            w_next     = S_E_MEM;
          end
          OP_JMP: begin
            pc_write = 1'b1;
            pc_sel   = 1'b1;
          end
          OP_JZ: begin
            pc_write = acc_zero;
            pc_sel   = acc_zero;
          end
          OP_HALT: w_next = S_HALT;
          default: illegal_op = 1'b1;
        endcase
      end
      S_E_MEM: begin
        if (w_opcode == OP_STORE) begin
          mem_wr = 1'b1;
          if (w_mem_ready) begin
            instr_done = 1'b1;
            w_next     = S_F_ADDR;
          end
        end else begin
          mem_rd = 1'b1;
          if (w_mem_ready) begin
            mbr_write = 1'b1;
            w_next    = S_E_WB;
          end
        end
      end
      S_E_WB: begin
        acc_write  = 1'b1;
        instr_done = 1'b1;
        w_next     = S_F_ADDR;
        case (w_opcode)
          OP_ADD:  alu_op = 2'b01;
          OP_SUB:  alu_op = 2'b10;
          default: alu_op = 2'b00;
        endcase
      end
      S_HALT: halted = 1'b1;
      default: w_next = S_F_ADDR;
    endcase

    // Reset overrides everything, so no strobe can leak out mid-instruction.
    if (reset) begin
      pc_write   = 1'b0;
      mar_write  = 1'b0;
      mbr_write  = 1'b0;
      ir_write   = 1'b0;
      acc_write  = 1'b0;
      pc_sel     = 1'b0;
      mar_sel    = 1'b0;
      alu_op     = 2'b00;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      halted     = 1'b0;
      illegal_op = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule
